// File: rtl/rng_pkg.sv
// Shared types and default LFSR constants for the
// digit sampler and its Galois LFSR core.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_HOLD
  } state_e;

  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [15:0] SEED16 = 16'hACE1;
  localparam logic [23:0] TAPS24 = 24'hE10000;
  localparam logic [23:0] SEED24 = 24'h0ACE1E;
  localparam logic [31:0] TAPS32 = 32'hA3000000;
  localparam logic [31:0] SEED32 = 32'h0ACE1E5D;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lfsr_galois_core.sv
// Galois LFSR register with seed load; a zero seed is
// replaced by SEED so the state can never lock up.
module lfsr_galois_core #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] TAPS  = 24'hE10000,
  parameter logic [WIDTH-1:0] SEED  = 24'h0ACE1E
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_load_val;

  assign w_shift = {1'b0, r_lfsr[WIDTH-1:1]};
  assign o_next  = r_lfsr[0] ? (w_shift ^ TAPS)
                             : w_shift;
  assign o_state = r_lfsr;

  assign w_load_val = (i_load_val == '0) ? SEED
                                         : i_load_val;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= w_load_val;
    end else if (i_step) begin
      r_lfsr <= o_next;
    end
  end

endmodule

// File: rtl/lfsr_digit_sampler.sv
// LFSR-driven rejection sampler producing uniform values in
// [OFFSET, OFFSET+RANGE-1] behind a one-entry valid/ready register.
module lfsr_digit_sampler
  import rng_pkg::*;
#(
  parameter int               WIDTH  = 24,
  parameter logic [WIDTH-1:0] TAPS   = TAPS24,
  parameter logic [WIDTH-1:0] SEED   = SEED24,
  parameter int               OUT_W  = 4,
  parameter int               RANGE  = 9,
  parameter int               OFFSET = 1
) (
  input  logic             in_clka,
  input  logic             in_rst,
  input  logic             in_enable,
  input  logic             in_seed_load,
  input  logic [WIDTH-1:0] in_seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      out_draws,
  output logic [15:0]      out_rejects
);

  localparam logic [OUT_W:0]   LP_RANGE = (OUT_W+1)'(RANGE);
  localparam logic [OUT_W-1:0] LP_OFF   = OUT_W'(OFFSET);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_data_nxt;
  logic [15:0]      r_draws;
  logic [15:0]      r_rejects;
  logic             w_draw_inc;
  logic             w_rej_inc;
  logic             w_step;
  logic             w_load;
  logic [WIDTH-1:0] w_lfsr;
  logic [WIDTH-1:0] w_next;
  logic [OUT_W-1:0] w_cand;
  logic [OUT_W-1:0] w_val;
  logic             w_accept;
  logic             w_unused;

  lfsr_galois_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .i_clk      (in_clka),
    .i_rst      (in_rst),
    .i_step     (w_step),
    .i_load     (w_load),
    .i_load_val (in_seed),
    .o_state    (w_lfsr),
    .o_next     (w_next)
  );

  assign w_cand   = w_next[OUT_W-1:0];
  assign w_accept = ({1'b0, w_cand} < LP_RANGE);
  assign w_val    = w_cand + LP_OFF;
  assign w_unused = ^{w_next[WIDTH-1:OUT_W], w_lfsr};

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_step      = 1'b0;
    w_load      = 1'b0;
    w_draw_inc  = 1'b0;
    w_rej_inc   = 1'b0;
    if (in_seed_load) begin
      w_load      = 1'b1;
      w_valid_nxt = 1'b0;
      w_state_nxt = in_enable ? ST_SEARCH : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_enable) w_state_nxt = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (in_enable) begin
            w_step = 1'b1;
            if (w_accept) begin
              w_data_nxt  = w_val;
              w_valid_nxt = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_rej_inc = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Consumer paces the LFSR: no step until the held value is taken
          if (out_ready) begin
            w_draw_inc = 1'b1;
            if (in_enable) begin
              w_step = 1'b1;
              if (w_accept) begin
                w_data_nxt = w_val;
              end else begin
                w_rej_inc   = 1'b1;
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_SEARCH;
              end
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge in_clka or posedge in_rst) begin
    if (in_rst) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_draws   <= '0;
      r_rejects <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      if (w_draw_inc) r_draws <= r_draws + 16'd1;
      if (w_rej_inc) r_rejects <= sat_inc16(r_rejects);
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_draws   = r_draws;
  assign out_rejects = r_rejects;

endmodule

// File: tb/tb_lfsr_digit_sampler.sv
// Directed and randomized checks of lfsr_digit_sampler
// against a sequence-level model of the sampler.
module tb_lfsr_digit_sampler;

  localparam logic [23:0] TAPS = 24'hE10000;
  localparam logic [23:0] SEED = 24'h0ACE1E;
  localparam int          NRUN = 20000;

  typedef int arr8_t[8];

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sl;
  logic        rdy;
  logic [23:0] seed;
  logic        valid;
  logic [3:0]  data;
  logic [15:0] draws;
  logic [15:0] rejects;

  int errors = 0;
  int checks = 0;

  logic [23:0] m;
  int          msteps;
  int          mrej;

  always #5 clk = ~clk;

  lfsr_digit_sampler dut (
    .in_clka      (clk),
    .in_rst       (rst),
    .in_enable    (en),
    .in_seed_load (sl),
    .in_seed      (seed),
    .out_valid    (valid),
    .out_ready    (rdy),
    .out_data     (data),
    .out_draws    (draws),
    .out_rejects  (rejects)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mstep(input logic [23:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  task automatic model_next(output int v);
    v = -1;
    while (v < 0) begin
      m = mstep(m);
      msteps++;
      if (int'(m[3:0]) < 9) v = int'(m[3:0]) + 1;
      else mrej++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sl = 1'b0;
    rdy = 1'b0; seed = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [23:0] s,
                      input logic e, input logic r);
    @(negedge clk);
    sl = 1'b1; seed = s; en = e; rdy = r;
    @(negedge clk);
    sl = 1'b0;
  endtask

  task automatic collect8(output arr8_t a);
    int i = 0;
    int n = 0;
    while (i < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (valid) begin
        a[i] = int'(data);
        i++;
      end
    end
    check("collect_count", i, 8);
  endtask

  initial begin
    int v, n, got, bad, cyc, oor, lo, hi;
    int hist[16];
    logic ok;
    arr8_t a1, a2;
    rst = 1'b1; en = 1'b0; sl = 1'b0;
    rdy = 1'b0; seed = '0;

    // Reset state
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_draws", draws, 0);
    check("rst_rejects", rejects, 0);
    check("rst_lfsr", dut.w_lfsr, SEED);

    // Seed 1: first step accepted immediately
    load(24'h000001, 1'b1, 1'b1);
    @(negedge clk);
    m = 24'h000001; msteps = 0; mrej = 0;
    model_next(v);
    check("t1_lfsr", dut.w_lfsr, 24'hE10000);
    check("t1_data", data, v);
    check("t1_valid", valid, 1);

    // Seed 0x1E: one reject, then value 8
    do_reset();
    load(24'h00001E, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_lfsr1", dut.w_lfsr, 24'h00000F);
    check("t2_rej1", rejects, 1);
    check("t2_valid1", valid, 0);
    @(negedge clk);
    check("t2_lfsr2", dut.w_lfsr, 24'hE10007);
    check("t2_data2", data, 8);
    check("t2_valid2", valid, 1);

    // Back-pressure holds value and LFSR
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(valid && data == 4'd8 &&
            dut.w_lfsr == 24'hE10007)) ok = 1'b0;
    end
    check("t3_stable", ok, 1);
    rdy = 1'b1; en = 1'b0;
    @(negedge clk);
    check("t3_draws", draws, 1);
    check("t3_valid_drop", valid, 0);
    rdy = 1'b0;

    // Seed load during HOLD discards held value
    en = 1'b1;
    n = 0;
    while (!valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("t5_hold", valid, 1);
    seed = 24'($urandom_range(1, 24'hFFFFFF));
    load(seed, 1'b1, 1'b0);
    check("t5_drop", valid, 0);
    m = seed; msteps = 0; mrej = 0;
    model_next(v);
    n = 0;
    while (!valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("t5_data", data, v);
    check("t5_latency", n, msteps);
    check("t5_draws_kept", draws, 1);

    // Seed 0 reproduces the post-reset sequence
    do_reset();
    en = 1'b1; rdy = 1'b1;
    collect8(a1);
    load(24'h000000, 1'b1, 1'b1);
    collect8(a2);
    m = SEED; msteps = 0; mrej = 0;
    for (int i = 0; i < 8; i++) begin
      model_next(v);
      check($sformatf("t4_rst%0d", i), a1[i], v);
      check($sformatf("t4_seed0_%0d", i), a2[i], v);
    end

    // Free run with random seed
    do_reset();
    seed = 24'($urandom_range(1, 24'hFFFFFF));
    load(seed, 1'b1, 1'b1);
    m = seed; msteps = 0; mrej = 0;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    got = 0; bad = 0; cyc = 0;
    while (got < NRUN && cyc < 60000) begin
      if (valid) begin
        model_next(v);
        if (int'(data) != v) bad++;
        hist[data]++;
        got++;
        if (got == NRUN) en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("t6_count", got, NRUN);
    check("t6_seq_bad", bad, 0);
    check("t6_draws", draws, NRUN);
    check("t6_rejects", rejects, mrej);
    check("t6_steps", int'(draws) + int'(rejects), msteps);
    check("t6_idle", valid, 0);
    oor = hist[0];
    for (int i = 10; i < 16; i++) oor += hist[i];
    check("t6_range", oor, 0);
    lo = NRUN - NRUN / 10;
    hi = NRUN + NRUN / 10;
    for (int i = 1; i <= 9; i++)
      check($sformatf("t6_hist%0d", i),
            (hist[i] * 9 >= lo) && (hist[i] * 9 <= hi), 1);

    // Asynchronous reset mid-run
    en = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t7_valid", valid, 0);
    check("t7_data", data, 0);
    check("t7_draws", draws, 0);
    check("t7_rejects", rejects, 0);
    check("t7_lfsr", dut.w_lfsr, SEED);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
